// File: rtl/dsi_tx_pkg.sv
// ============================================================================
//  Module      : dsi_tx_pkg
//  Description : Shared DSI TX definitions: data-type codes, line scheduler
//                state encoding and the CRC-16 32-bit update step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dsi_tx_pkg;

  // DSI data-type codes (6-bit DT field of the data identifier)
  localparam logic [5:0] c_dt_vss    = 6'h01;
  localparam logic [5:0] c_dt_hss    = 6'h21;
  localparam logic [5:0] c_dt_rgb888 = 6'h3E;

  // CRC-16/CCITT in reflected form, as used for DSI long-packet footers
  localparam logic [15:0] c_crc_init     = 16'hFFFF;
  localparam logic [15:0] c_crc_poly_rev = 16'h8408;

  // Line scheduler states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_HDR     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_FTR     = 3'd4
  } line_state_t;

  // Advance the CRC over one 32-bit word; byte 0 (bits [7:0]) goes first and
  // each byte is consumed LSB first, so bit i of the word is bit i in time.
  function automatic logic [15:0] crc16_step32(input logic [15:0] crc,
                                               input logic [31:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 32; i++) begin
      fb = c[0] ^ data[i];
      c  = {1'b0, c[15:1]} ^ (fb ? c_crc_poly_rev : 16'h0000);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dsi_ecc_24.sv
// ============================================================================
//  Module      : dsi_ecc_24
//  Description : Combinational DSI packet-header ECC. Six Hamming parity bits
//                over header bits [23:0]; bits [7:6] of the ECC byte are 0.
//                Also used by the short-packet command path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsi_ecc_24 (
  input  logic [23:0] hdr,
  output logic [7:0]  ecc
);

  logic [23:0] w_d;

  assign w_d = hdr;

  // Parity equations of the DSI header ECC
  assign ecc[0] = w_d[0]  ^ w_d[1]  ^ w_d[2]  ^ w_d[4]  ^ w_d[5]  ^ w_d[7]  ^
                  w_d[10] ^ w_d[11] ^ w_d[13] ^ w_d[16] ^ w_d[20] ^ w_d[21] ^
                  w_d[22] ^ w_d[23];
  assign ecc[1] = w_d[0]  ^ w_d[1]  ^ w_d[3]  ^ w_d[4]  ^ w_d[6]  ^ w_d[8]  ^
                  w_d[10] ^ w_d[12] ^ w_d[14] ^ w_d[17] ^ w_d[20] ^ w_d[21] ^
                  w_d[22] ^ w_d[23];
  assign ecc[2] = w_d[0]  ^ w_d[2]  ^ w_d[3]  ^ w_d[5]  ^ w_d[6]  ^ w_d[9]  ^
                  w_d[11] ^ w_d[12] ^ w_d[15] ^ w_d[18] ^ w_d[20] ^ w_d[21] ^
                  w_d[22];
  assign ecc[3] = w_d[1]  ^ w_d[2]  ^ w_d[3]  ^ w_d[7]  ^ w_d[8]  ^ w_d[9]  ^
                  w_d[13] ^ w_d[14] ^ w_d[15] ^ w_d[19] ^ w_d[20] ^ w_d[21] ^
                  w_d[23];
  assign ecc[4] = w_d[4]  ^ w_d[5]  ^ w_d[6]  ^ w_d[7]  ^ w_d[8]  ^ w_d[9]  ^
                  w_d[16] ^ w_d[17] ^ w_d[18] ^ w_d[19] ^ w_d[20] ^ w_d[22] ^
                  w_d[23];
  assign ecc[5] = w_d[10] ^ w_d[11] ^ w_d[12] ^ w_d[13] ^ w_d[14] ^ w_d[15] ^
                  w_d[16] ^ w_d[17] ^ w_d[18] ^ w_d[19] ^ w_d[21] ^ w_d[22] ^
                  w_d[23];
  assign ecc[7:6] = 2'b00;

endmodule

`default_nettype wire

// File: rtl/dsi_tx_line_scheduler.sv
// ============================================================================
//  Module      : dsi_tx_line_scheduler
//  Description : Sequences one DSI video line at a time from the TX pixel
//                buffer: sync short packet (VSS/HSS), long-packet header,
//                payload straight from the show-ahead buffer, 2-byte footer,
//                then an idle gap. PHY-side clock domain.
//                Build option DSI_TX_CRC_EN: real CRC-16 footer; without it
//                the footer is 16'h0000 and no CRC logic exists.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsi_tx_line_scheduler
  import dsi_tx_pkg::*;
#(
  parameter int         LINE_BYTES      = 640,
  parameter int         LINES_PER_FRAME = 480,
  parameter int         LINE_GAP        = 16,
  parameter logic [7:0] DATA_TYPE       = {2'b00, c_dt_rgb888},
  parameter logic [1:0] VC              = 2'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        err_clr,
  input  logic [31:0] fifo_data,
  input  logic        fifo_not_empty,
  input  logic        fifo_line_ready,
  output logic        fifo_read_ack,
  output logic [31:0] out_data,
  output logic [3:0]  out_strb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic [15:0] line_cnt,
  output logic        underflow_err
);

  localparam int          c_words     = LINE_BYTES / 4;
  localparam logic [13:0] c_last_word = 14'(c_words - 1);
  localparam logic [15:0] c_wc        = 16'(LINE_BYTES);
  localparam logic [15:0] c_last_line = 16'(LINES_PER_FRAME - 1);
  localparam logic [15:0] c_gap       = 16'(LINE_GAP);

  line_state_t r_state;
  line_state_t w_state_nxt;

  logic [15:0] r_gap_cnt;
  logic [13:0] r_word_cnt;
  logic [15:0] r_line_cnt;
  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic [3:0]  r_out_strb;
  logic        r_underflow;

  logic        w_in_payload;
  logic        w_accept;
  logic        w_start;
  logic        w_last_word;
  logic [23:0] w_sync_hdr;
  logic [23:0] w_long_hdr;
  logic [7:0]  w_sync_ecc;
  logic [7:0]  w_long_ecc;
  logic [15:0] w_crc_footer;

  // --------------------------------------------------------------------------
  // Packet headers and their ECC bytes
  // --------------------------------------------------------------------------
  assign w_sync_hdr = {8'h00, 8'h00, VC, (r_line_cnt == 16'd0) ? c_dt_vss : c_dt_hss};
  assign w_long_hdr = {c_wc[15:8], c_wc[7:0], VC, DATA_TYPE[5:0]};

  dsi_ecc_24 u_ecc_sync (
    .hdr (w_sync_hdr),
    .ecc (w_sync_ecc)
  );

  dsi_ecc_24 u_ecc_long (
    .hdr (w_long_hdr),
    .ecc (w_long_ecc)
  );

  // --------------------------------------------------------------------------
  // Stream outputs: PAYLOAD passes the buffer through with zero latency; every
  // other state drives the registered word.
  // --------------------------------------------------------------------------
  assign w_in_payload  = (r_state == ST_PAYLOAD);
  assign out_valid     = w_in_payload ? fifo_not_empty : r_out_valid;
  assign out_data      = w_in_payload ? fifo_data      : r_out_data;
  assign out_strb      = w_in_payload ? 4'hF           : r_out_strb;
  assign w_accept      = out_valid & out_ready;
  assign fifo_read_ack = w_in_payload & w_accept;

  assign busy          = (r_state != ST_IDLE);
  assign line_cnt      = r_line_cnt;
  assign underflow_err = r_underflow;

  // --------------------------------------------------------------------------
  // Footer CRC
  // --------------------------------------------------------------------------
`ifdef DSI_TX_CRC_EN
  logic [15:0] r_crc;
  logic [15:0] w_crc_next;

  assign w_crc_next   = crc16_step32(r_crc, fifo_data);
  // The footer is captured on the last pop, so it must include that word.
  assign w_crc_footer = w_crc_next;

  // Running payload CRC, reseeded as the header is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= c_crc_init;
    end else if ((r_state == ST_HDR) && w_accept) begin
      r_crc <= c_crc_init;
    end else if (w_in_payload && w_accept) begin
      r_crc <= w_crc_next;
    end
  end
`else
  assign w_crc_footer = 16'h0000;
`endif

  // --------------------------------------------------------------------------
  // Line state machine
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; enable only gates the start of a new line
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_last_word = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start = (r_gap_cnt == 16'd0) && enable && fifo_line_ready;
        if (w_start) begin
          w_state_nxt = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (w_accept) begin
          w_state_nxt = ST_HDR;
        end
      end
      ST_HDR: begin
        if (w_accept) begin
          w_state_nxt = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        w_last_word = (r_word_cnt == c_last_word);
        if (w_accept && w_last_word) begin
          w_state_nxt = ST_FTR;
        end
      end
      ST_FTR: begin
        if (w_accept) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------

  // Registered output word: loaded one state ahead so it is valid on entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 32'h0000_0000;
      r_out_strb  <= 4'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {w_sync_ecc, w_sync_hdr};
            r_out_strb  <= 4'hF;
          end
        end
        ST_SYNC: begin
          if (w_accept) begin
            r_out_data <= {w_long_ecc, w_long_hdr};
          end
        end
        ST_HDR: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0000_0000;
            r_out_strb  <= 4'h0;
          end
        end
        ST_PAYLOAD: begin
          if (w_accept && w_last_word) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {16'h0000, w_crc_footer};
            r_out_strb  <= 4'h3;
          end
        end
        ST_FTR: begin
          if (w_accept) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0000_0000;
            r_out_strb  <= 4'h0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_out_data  <= 32'h0000_0000;
          r_out_strb  <= 4'h0;
        end
      endcase
    end
  end

  // Payload word counter, cleared as the header goes out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= 14'd0;
    end else if ((r_state == ST_HDR) && w_accept) begin
      r_word_cnt <= 14'd0;
    end else if (w_in_payload && w_accept) begin
      r_word_cnt <= r_word_cnt + 14'd1;
    end
  end

  // Inter-line gap: loaded when the footer leaves, counts down while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap_cnt <= 16'd0;
    end else if ((r_state == ST_FTR) && w_accept) begin
      r_gap_cnt <= c_gap;
    end else if ((r_state == ST_IDLE) && (r_gap_cnt != 16'd0)) begin
      r_gap_cnt <= r_gap_cnt - 16'd1;
    end
  end

  // Line index within the frame, advanced when the footer is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_cnt <= 16'd0;
    end else if ((r_state == ST_FTR) && w_accept) begin
      if (r_line_cnt == c_last_line) begin
        r_line_cnt <= 16'd0;
      end else begin
        r_line_cnt <= r_line_cnt + 16'd1;
      end
    end
  end

  // Sticky underflow flag; a new underflow beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underflow <= 1'b0;
    end else if (w_in_payload && !fifo_not_empty) begin
      r_underflow <= 1'b1;
    end else if (err_clr) begin
      r_underflow <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dsi_tx_line_scheduler.sv
// ============================================================================
//  Module      : tb_dsi_tx_line_scheduler
//  Description : Self-checking bench for dsi_tx_line_scheduler. A buffer
//                model feeds the DUT; a word-level scoreboard built from the
//                packet rules checks the accepted stream, handshake, timing,
//                line counter and underflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsi_tx_line_scheduler;

  localparam int         LB  = 8;
  localparam int         LPF = 2;
  localparam int         GAP = 3;
  localparam int         NW  = LB / 4;
  localparam logic [7:0] DT  = 8'h3E;
  localparam logic [1:0] VCH = 2'd0;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        err_clr;
  logic [31:0] fifo_data;
  logic        fifo_not_empty;
  logic        fifo_line_ready;
  logic        fifo_read_ack;
  logic [31:0] out_data;
  logic [3:0]  out_strb;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [15:0] line_cnt;
  logic        underflow_err;

  dsi_tx_line_scheduler #(
    .LINE_BYTES      (LB),
    .LINES_PER_FRAME (LPF),
    .LINE_GAP        (GAP),
    .DATA_TYPE       (DT),
    .VC              (VCH)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .err_clr         (err_clr),
    .fifo_data       (fifo_data),
    .fifo_not_empty  (fifo_not_empty),
    .fifo_line_ready (fifo_line_ready),
    .fifo_read_ack   (fifo_read_ack),
    .out_data        (out_data),
    .out_strb        (out_strb),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .busy            (busy),
    .line_cnt        (line_cnt),
    .underflow_err   (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
  } word_t;

  logic [31:0] fq[$];
  word_t       exp_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          lines_pushed = 0;
  int          pos = 0;
  int          footers = 0;
  int          hold_empty = 0;
  int          mode = 0;
  logic        exp_err = 1'b0;

  logic        prev_busy = 1'b0;
  logic        prev_start_cond = 1'b0;
  int          idle_run = 1000;
  int          prev_idle_run = 1000;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [3:0]  prev_strb = '0;
  int          busy_len = 0;
  logic        stalled = 1'b0;
  int          acks = 0;
  int          lowv_cnt = 0;

  logic        s_acc, s_pop, s_in_pay, s_fne;
  logic [31:0] first_word = '0;
  logic        got_first = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // DSI header ECC from the per-bit syndrome table
  function automatic logic [7:0] ecc_model(input logic [23:0] h);
    logic [5:0] codes [0:23];
    logic [5:0] e;
    codes = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
              6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
              6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
    e = 6'h00;
    for (int i = 0; i < 24; i++) begin
      if (h[i]) e = e ^ codes[i];
    end
    return {2'b00, e};
  endfunction

  // Byte-serial reflected CRC-16 over the line payload
  function automatic logic [15:0] crc_model(input logic [31:0] w0, input logic [31:0] w1);
    logic [15:0] c;
    logic [63:0] bytes;
    c = 16'h0000;
    bytes = {w1, w0};
`ifdef DSI_TX_CRC_EN
    c = 16'hFFFF;
    for (int b = 0; b < 8; b++) begin
      c = c ^ {8'h00, bytes[8*b +: 8]};
      for (int k = 0; k < 8; k++) begin
        c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      end
    end
`endif
    return c;
  endfunction

  // Queue one line into the buffer and its expected word stream
  task automatic push_line(input logic [31:0] w0, input logic [31:0] w1);
    logic [23:0] h;
    logic [5:0]  di;
    logic [15:0] wc;
    logic [7:0]  dt;
    wc = 16'(LB);
    dt = DT;
    di = ((lines_pushed % LPF) == 0) ? 6'h01 : 6'h21;
    h  = {16'h0000, VCH, di};
    exp_q.push_back('{d: {ecc_model(h), h}, s: 4'hF});
    h  = {wc[15:8], wc[7:0], VCH, dt[5:0]};
    exp_q.push_back('{d: {ecc_model(h), h}, s: 4'hF});
    exp_q.push_back('{d: w0, s: 4'hF});
    exp_q.push_back('{d: w1, s: 4'hF});
    exp_q.push_back('{d: {16'h0000, crc_model(w0, w1)}, s: 4'h3});
    fq.push_back(w0);
    fq.push_back(w1);
    lines_pushed++;
  endtask

  task automatic apply_mode_stim();
    if (mode == 1) begin
      out_ready = ~out_ready;
    end else if (mode == 2) begin
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 9) != 0);
      err_clr   = ($urandom_range(0, 9) == 0);
      if (pos >= 2 && pos < 2 + NW && hold_empty == 0 && $urandom_range(0, 19) == 0)
        hold_empty = $urandom_range(1, 3);
    end
  endtask

  task automatic drive_fifo();
    fifo_not_empty  = (fq.size() > 0) && (hold_empty == 0);
    fifo_data       = (fq.size() > 0) ? fq[0] : 32'hDEAD_BEEF;
    fifo_line_ready = (fq.size() >= NW);
  endtask

  task automatic sample_and_check();
    logic  in_pay;
    word_t w;
    in_pay = (pos >= 2) && (pos < 2 + NW);

    if (!prev_busy && !prev_start_cond)      chk("no_start_without_cond", busy, 0);
    if (!prev_busy && prev_idle_run < GAP)   chk("gap_respected", busy, 0);
    if (!prev_busy && prev_start_cond && prev_idle_run > GAP) chk("start_on_time", busy, 1);

    if (!busy && prev_busy) begin
      chk("acks_per_line", acks, NW);
      if (!stalled) chk("line_len", busy_len, 3 + NW);
    end
    if (busy && !prev_busy) begin
      busy_len = 0;
      stalled  = 1'b0;
      acks     = 0;
    end
    if (busy) begin
      busy_len++;
      if (!out_ready || (in_pay && !fifo_not_empty)) stalled = 1'b1;
    end

    chk("line_cnt", {16'h0000, line_cnt}, footers % LPF);
    chk("underflow_err", underflow_err, exp_err);
    if (!busy)     chk("idle_valid_low", out_valid, 0);
    if (pos != 0)  chk("busy_mid_line", busy, 1);
    if (in_pay) begin
      chk("pay_valid", out_valid, fifo_not_empty);
      if (!out_valid) lowv_cnt++;
    end
    chk("read_ack", fifo_read_ack, in_pay && fifo_not_empty && out_ready);
    if (prev_stall && !(in_pay && !fifo_not_empty)) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
      chk("hold_strb", out_strb, prev_strb);
    end

    if (out_valid && out_ready) begin
      if (!got_first) begin
        first_word = out_data;
        got_first  = 1'b1;
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_word", out_valid, 0);
      end else begin
        w = exp_q[0];
        chk("word_data", out_data, w.d);
        chk("word_strb", out_strb, w.s);
      end
    end

    prev_busy       = busy;
    prev_start_cond = enable && fifo_line_ready;
    idle_run        = busy ? 0 : idle_run + 1;
    prev_idle_run   = idle_run;
    prev_stall      = out_valid && !out_ready;
    prev_data       = out_data;
    prev_strb       = out_strb;
    s_acc           = out_valid && out_ready;
    s_pop           = fifo_read_ack;
    s_in_pay        = in_pay;
    s_fne           = fifo_not_empty;
  endtask

  task automatic update_model();
    if (s_pop && fq.size() > 0) void'(fq.pop_front());
    if (s_pop) acks++;
    if (s_in_pay && !s_fne) exp_err = 1'b1;
    else if (err_clr)       exp_err = 1'b0;
    if (s_acc && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      pos++;
      if (pos == 3 + NW) begin
        pos = 0;
        footers++;
      end
    end
    if (hold_empty > 0) hold_empty--;
  endtask

  // One clock: inputs set after the falling edge, outputs checked before the
  // rising edge, model advanced after it.
  task automatic run_cycle();
    apply_mode_stim();
    drive_fifo();
    #1;
    sample_and_check();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic run_until_footers(input int target, input int budget);
    int n;
    n = 0;
    while (footers < target && n < budget) begin
      run_cycle();
      n++;
    end
    chk("lines_done_in_budget", footers, target);
  endtask

  task automatic run_until_pos(input int p, input int budget);
    int n;
    n = 0;
    while (pos != p && n < budget) begin
      run_cycle();
      n++;
    end
    chk("reach_pos_in_budget", pos, p);
  endtask

  initial begin
    int lc;
    rst_n = 1'b0; enable = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    fifo_data = '0; fifo_not_empty = 1'b0; fifo_line_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_strb", out_strb, 0);
    chk("rst_read_ack", fifo_read_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_underflow", underflow_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lines 0..2: VSS, HSS, then VSS again after the wrap, ready held high
    push_line(32'h1111_1111, 32'h2222_2222);
    push_line($urandom, $urandom);
    push_line(32'h0000_0000, 32'h0000_0000);
    enable = 1'b1;
    run_until_footers(3, 200);
    chk("first_sync_word", first_word, 32'h0700_0001);

    // Ready toggling every cycle
    mode = 1;
    push_line($urandom, $urandom);
    push_line($urandom, $urandom);
    run_until_footers(5, 300);
    mode = 0;
    out_ready = 1'b1;

    // Buffer underflow after the first payload word
    push_line(32'hA5A5_0001, 32'h5A5A_0002);
    run_until_pos(3, 100);
    lowv_cnt = 0;
    hold_empty = 5;
    repeat (5) run_cycle();
    chk("uf_stall_cycles", lowv_cnt, 5);
    run_until_footers(6, 100);
    chk("uf_flag_set", underflow_err, 1);
    err_clr = 1'b1;
    run_cycle();
    err_clr = 1'b0;
    run_cycle();
    chk("uf_flag_cleared", underflow_err, 0);

    // Enable dropped mid-payload: line completes, nothing new while low
    push_line($urandom, $urandom);
    push_line($urandom, $urandom);
    run_until_pos(2, 100);
    enable = 1'b0;
    run_until_footers(7, 100);
    repeat (20) run_cycle();
    chk("no_line_while_disabled", footers, 7);
    enable = 1'b1;
    run_until_footers(8, 100);

    // Randomised traffic
    mode = 2;
    for (int i = 0; i < 8; i++) push_line($urandom, $urandom);
    run_until_footers(16, 3000);
    mode = 0;
    enable = 1'b1; out_ready = 1'b1; err_clr = 1'b0;

    // Reset in the middle of a line
    lc = footers;
    push_line($urandom, $urandom);
    run_until_pos(2, 100);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_line_cnt", line_cnt, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_read_ack", fifo_read_ack, 0);
    chk("midrst_underflow", underflow_err, 0);
    chk("midrst_lines_before", lc, 16);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
